// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared CPU bus definitions: arbiter state/owner encodings, bus widths and
// the round-robin owner selection used by the cache-to-system-bus arbiter.
package cpu_bus_arbiter_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_MASK_W = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bus_arb_state_t;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } bus_owner_t;

    // A lone requester always wins; on a tie the one not served last wins.
    function automatic bus_owner_t pick_owner(
        input logic       ic_req,
        input logic       dc_req,
        input bus_owner_t last_grant
    );
        bus_owner_t owner;
        if (ic_req && dc_req) begin
            if (last_grant == REQ_DC) owner = REQ_IC;
            else                      owner = REQ_DC;
        end else if (ic_req) begin
            owner = REQ_IC;
        end else begin
            owner = REQ_DC;
        end
        return owner;
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing the CPU system bus between the instruction cache
// (read-only) and the data cache, with an optional watchdog for hung transfers.
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,

    input  logic                  i_ic_request,
    input  logic [BUS_ADDR_W-1:0] i_ic_address,
    output logic                  o_ic_ready,
    output logic [BUS_DATA_W-1:0] o_ic_rdata,

    input  logic                  i_dc_request,
    input  logic                  i_dc_rw,
    input  logic [BUS_ADDR_W-1:0] i_dc_address,
    input  logic [BUS_DATA_W-1:0] i_dc_wdata,
    input  logic [BUS_MASK_W-1:0] i_dc_wmask,
    output logic                  o_dc_ready,
    output logic [BUS_DATA_W-1:0] o_dc_rdata,

    output logic                  o_bus_request,
    output logic                  o_bus_rw,
    output logic [BUS_ADDR_W-1:0] o_bus_address,
    output logic [BUS_DATA_W-1:0] o_bus_wdata,
    output logic [BUS_MASK_W-1:0] o_bus_wmask,
    input  logic                  i_bus_ready,
    input  logic [BUS_DATA_W-1:0] i_bus_rdata,

    output logic                  o_timeout
);

    localparam int CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1) : 1;

    bus_arb_state_t        state_q, state_d;
    bus_owner_t            last_grant_q, last_grant_d;
    bus_owner_t            owner_sel;
    logic                  bus_request_q, bus_request_d;
    logic                  bus_rw_q, bus_rw_d;
    logic [BUS_ADDR_W-1:0] bus_address_q, bus_address_d;
    logic [BUS_DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [BUS_MASK_W-1:0] bus_wmask_q, bus_wmask_d;

    logic in_busy;
    logic wdog_fire;
    logic xfer_end;

    // A reset cycle never completes a transfer, even if the bus acks in it.
    assign in_busy  = (state_q == BUSY) && !i_reset;
    assign xfer_end = in_busy && (i_bus_ready || wdog_fire);

    generate
        if (TIMEOUT > 0) begin : g_wdog
            logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;

            always_comb begin
                wdog_cnt_d = wdog_cnt_q;
                if (state_q != BUSY) begin
                    wdog_cnt_d = '0;
                end else if (!i_bus_ready) begin
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    wdog_cnt_q <= '0;
                end else begin
                    wdog_cnt_q <= wdog_cnt_d;
                end
            end

            // Fires in the TIMEOUT-th silent BUSY cycle; a real ack in that cycle wins.
            assign wdog_fire = (state_q == BUSY) && !i_bus_ready &&
                               (wdog_cnt_q == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_wdog
            assign wdog_fire = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        bus_request_d = bus_request_q;
        bus_rw_d      = bus_rw_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;
        bus_wmask_d   = bus_wmask_q;
        owner_sel     = pick_owner(i_ic_request, i_dc_request, last_grant_q);

        case (state_q)
            IDLE: begin
                if (i_ic_request || i_dc_request) begin
                    last_grant_d  = owner_sel;
                    bus_request_d = 1'b1;
                    state_d       = BUSY;
                    if (owner_sel == REQ_IC) begin
                        bus_rw_d      = 1'b0;
                        bus_address_d = i_ic_address;
                        bus_wdata_d   = '0;
                        bus_wmask_d   = '0;
                    end else begin
                        bus_rw_d      = i_dc_rw;
                        bus_address_d = i_dc_address;
                        bus_wdata_d   = i_dc_wdata;
                        bus_wmask_d   = i_dc_rw ? i_dc_wmask : '0;
                    end
                end
            end
            BUSY: begin
                if (i_bus_ready || wdog_fire) begin
                    bus_request_d = 1'b0;
                    state_d       = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= IDLE;
            last_grant_q  <= REQ_DC;
            bus_request_q <= 1'b0;
            bus_rw_q      <= 1'b0;
            bus_address_q <= '0;
            bus_wdata_q   <= '0;
            bus_wmask_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            bus_request_q <= bus_request_d;
            bus_rw_q      <= bus_rw_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_wmask_q   <= bus_wmask_d;
        end
    end

    assign o_bus_request = bus_request_q;
    assign o_bus_rw      = bus_rw_q;
    assign o_bus_address = bus_address_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_bus_wmask   = bus_wmask_q;

    // During BUSY last_grant_q is the current owner.
    assign o_ic_ready = xfer_end && (last_grant_q == REQ_IC);
    assign o_dc_ready = xfer_end && (last_grant_q == REQ_DC);
    assign o_ic_rdata = (o_ic_ready && i_bus_ready) ? i_bus_rdata : '0;
    assign o_dc_rdata = (o_dc_ready && i_bus_ready) ? i_bus_rdata : '0;
    assign o_timeout  = in_busy && wdog_fire;

endmodule
